uart_cmd_master: RTL and testbench
==================================

UART_CMD_MASTER -- requirements
Module: uart_cmd_master

Interface
REQ-001 Parameters SHALL be: FRAME_WIDTH, default 8, UART byte width; ALU_DATA_WIDTH, default 16, ALU result width; REG_FILE_ADDR_WIDTH, default 4, register address width; ALU_FUNC_WIDTH, default 4, ALU function code width; TIMEOUT_CYCLES, default 1024, response timeout in CLK cycles.
REQ-002 CLK  input  1  the block's single clock, rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  command request present.
REQ-005 req_ready  output  1  block idle and accepting a request.
REQ-006 req_op  input  2  command: 00 reg write, 01 reg read, 10 ALU with operands, 11 ALU without operands.
REQ-007 req_addr  input  REG_FILE_ADDR_WIDTH  register address.
REQ-008 req_wdata, req_opa, req_opb  input  FRAME_WIDTH each  write data, operand A, operand B.
REQ-009 req_func  input  ALU_FUNC_WIDTH  ALU function code.
REQ-010 tx_data  output  FRAME_WIDTH  byte to the UART transmitter.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-013 rx_data  input  FRAME_WIDTH  byte from the UART receiver.
REQ-014 rx_valid  input  1  single-cycle strobe qualifying rx_data.
REQ-015 rsp_valid  output  1  single-cycle completion strobe.
REQ-016 rsp_data  output  ALU_DATA_WIDTH  response payload.
REQ-017 rsp_err  output  1  response timed out; qualified by rsp_valid.

Function
REQ-018 The FSM SHALL have states IDLE, SEND, WAIT_LO, WAIT_HI, DONE.
REQ-019 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a cycle with req_valid&&req_ready, and all request fields SHALL be latched then.
REQ-020 Byte sequences SHALL be: write AA,addr,wdata; read BB,addr; ALU-op CC,opa,opb,func; ALU-nop DD,func; addr and func are zero-extended to 8 bits.
REQ-021 tx_valid SHALL assert in the cycle after acceptance and hold tx_data stable until tx_ready; the next byte SHALL be presented in the cycle after each handshake.
REQ-022 After the last byte handshake: write -> DONE; read -> WAIT_LO; ALU -> WAIT_LO then WAIT_HI.
REQ-023 In WAIT_LO, rx_valid SHALL capture rsp_data[7:0]; read then goes to DONE with rsp_data[15:8]=0, and ALU goes to WAIT_HI.
REQ-024 In WAIT_HI, rx_valid SHALL capture rsp_data[15:8] and go to DONE.
REQ-025 DONE SHALL pulse rsp_valid for one cycle and then return to IDLE; write SHALL return rsp_data=0.
REQ-026 rx_valid outside WAIT_LO/WAIT_HI SHALL be ignored; rsp_data SHALL hold between responses.
REQ-027 tx_ready while tx_valid=0 SHALL be ignored.

Reset
REQ-028 RST low SHALL force IDLE immediately, including mid-frame and mid-wait, with req_ready=1 once released, tx_valid=0, tx_data=0, rsp_valid=0, rsp_data=0, rsp_err=0, and the timeout counter at 0.

Configuration
REQ-029 With RESP_TIMEOUT_EN defined:
- a counter SHALL clear on entry to WAIT_LO/WAIT_HI and on each accepted rx_valid;
- reaching TIMEOUT_CYCLES-1 in a wait state SHALL go to DONE with rsp_err=1 and rsp_data=0.
REQ-030 Without RESP_TIMEOUT_EN: no counter; wait states SHALL wait indefinitely; rsp_err SHALL be constant 0.

Structure
REQ-031 Package sys_cmd_pkg SHALL hold:
- opcode constants CMD_RF_WR=AA, CMD_RF_RD=BB, CMD_ALU_OP=CC, CMD_ALU_NOP=DD;
- the req_op encoding;
- the FSM state enumeration.
REQ-032 No sub-module; the byte sequencer and timeout counter are inline.

Verification
REQ-033 Write addr 0, wdata 02, tx_ready always 1 -> tx bytes AA,00,02 on consecutive handshakes; rsp_valid one cycle later with rsp_data 0000, rsp_err 0.
REQ-034 Read addr 0, then rx byte 02 -> tx bytes BB,00; rsp_data 0002.
REQ-035 ALU-op opa 02, opb 03, func 0, with rx 05 then 00 -> tx bytes CC,02,03,00; rsp_data 0005; tx_ready held low 5 cycles mid-frame -> tx_data stable throughout.
REQ-036 ALU-nop func 1 with rx 34,12 -> tx bytes DD,01; rsp_data 1234; a spurious rx_valid in IDLE -> no effect.
REQ-037 RESP_TIMEOUT_EN, read with no rx byte -> rsp_valid with rsp_err 1 exactly TIMEOUT_CYCLES cycles after entering WAIT_LO.
REQ-038 RST low during the second byte of a write -> tx_valid 0 and req_ready 1 immediately; a new request after release completes normally.

Source files
------------

// File: rtl/sys_cmd_pkg.sv
// Shared command definitions for the UART command master: opcode bytes,
// request-op encoding and the sequencer state enumeration.
package sys_cmd_pkg;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   typedef enum logic [1:0] {
      OP_RF_WR   = 2'b00,
      OP_RF_RD   = 2'b01,
      OP_ALU_OP  = 2'b10,
      OP_ALU_NOP = 2'b11
   } req_op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEND    = 3'd1,
      ST_WAIT_LO = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   function automatic logic [7:0] op_code(input req_op_e op);
      case (op)
         OP_RF_WR:  op_code = CMD_RF_WR;
         OP_RF_RD:  op_code = CMD_RF_RD;
         OP_ALU_OP: op_code = CMD_ALU_OP;
         default:   op_code = CMD_ALU_NOP;
      endcase
   endfunction

   // Index of the final byte of each command frame.
   function automatic logic [1:0] frame_last(input req_op_e op);
      case (op)
         OP_RF_WR:  frame_last = 2'd2;
         OP_ALU_OP: frame_last = 2'd3;
         default:   frame_last = 2'd1;
      endcase
   endfunction

endpackage

// File: rtl/uart_cmd_master.sv
// UART command master: serialises register/ALU commands as byte frames and
// collects the one- or two-byte reply. Define RESP_TIMEOUT_EN for a reply timeout.
//
// state      | meaning
// IDLE       | req_ready high, waiting for a request
// SEND       | presenting frame bytes to the transmitter
// WAIT_LO    | waiting for the low reply byte
// WAIT_HI    | waiting for the high reply byte (ALU only)
// DONE       | rsp_valid pulse, then back to IDLE
module uart_cmd_master
   import sys_cmd_pkg::*;
#(
   parameter int FRAME_WIDTH         = 8,
   parameter int ALU_DATA_WIDTH      = 16,
   parameter int REG_FILE_ADDR_WIDTH = 4,
   parameter int ALU_FUNC_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES      = 1024
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [1:0]                     req_op,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] req_addr,
   input  logic [FRAME_WIDTH-1:0]         req_wdata,
   input  logic [FRAME_WIDTH-1:0]         req_opa,
   input  logic [FRAME_WIDTH-1:0]         req_opb,
   input  logic [ALU_FUNC_WIDTH-1:0]      req_func,
   output logic [FRAME_WIDTH-1:0]         tx_data,
   output logic                           tx_valid,
   input  logic                           tx_ready,
   input  logic [FRAME_WIDTH-1:0]         rx_data,
   input  logic                           rx_valid,
   output logic                           rsp_valid,
   output logic [ALU_DATA_WIDTH-1:0]      rsp_data,
   output logic                           rsp_err
);

   state_e                         state;
   req_op_e                        op_q;
   logic [REG_FILE_ADDR_WIDTH-1:0] addr_q;
   logic [FRAME_WIDTH-1:0]         wdata_q;
   logic [FRAME_WIDTH-1:0]         opa_q;
   logic [FRAME_WIDTH-1:0]         opb_q;
   logic [ALU_FUNC_WIDTH-1:0]      func_q;
   logic [FRAME_WIDTH-1:0]         lo_q;
   logic [1:0]                     idx;

`ifdef RESP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign rsp_err = 1'b0;
`endif

   assign req_ready = (state == ST_IDLE);

   // Frame payload bytes after the opcode, taken from the latched request.
   function automatic logic [FRAME_WIDTH-1:0] frame_byte(input logic [1:0] i);
      case (op_q)
         OP_RF_WR:  frame_byte = (i == 2'd1) ? FRAME_WIDTH'(addr_q) : wdata_q;
         OP_RF_RD:  frame_byte = FRAME_WIDTH'(addr_q);
         OP_ALU_OP: begin
            case (i)
               2'd1:    frame_byte = opa_q;
               2'd2:    frame_byte = opb_q;
               default: frame_byte = FRAME_WIDTH'(func_q);
            endcase
         end
         default:   frame_byte = FRAME_WIDTH'(func_q);
      endcase
   endfunction

   function automatic logic [ALU_DATA_WIDTH-1:0] join_rsp(input logic [FRAME_WIDTH-1:0] hi,
                                                          input logic [FRAME_WIDTH-1:0] lo);
      logic [2*FRAME_WIDTH-1:0] w;
      w = {hi, lo};
      join_rsp = ALU_DATA_WIDTH'(w);
   endfunction

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= ST_IDLE;
         op_q      <= OP_RF_WR;
         addr_q    <= '0;
         wdata_q   <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         func_q    <= '0;
         lo_q      <= '0;
         idx       <= '0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
`ifdef RESP_TIMEOUT_EN
         rsp_err   <= 1'b0;
         tmo_cnt   <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q     <= req_op_e'(req_op);
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  opa_q    <= req_opa;
                  opb_q    <= req_opb;
                  func_q   <= req_func;
                  idx      <= 2'd0;
                  tx_data  <= FRAME_WIDTH'(op_code(req_op_e'(req_op)));
                  tx_valid <= 1'b1;
                  state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (tx_valid && tx_ready) begin
                  if (idx == frame_last(op_q)) begin
                     tx_valid <= 1'b0;
                     if (op_q == OP_RF_WR) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
`ifdef RESP_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= ST_DONE;
                     end else begin
`ifdef RESP_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                        state     <= ST_WAIT_LO;
                     end
                  end else begin
                     tx_data <= frame_byte(idx + 2'd1);
                     idx     <= idx + 2'd1;
                  end
               end
            end
            ST_WAIT_LO: begin
               if (rx_valid) begin
                  if (op_q == OP_RF_RD) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= join_rsp('0, rx_data);
`ifdef RESP_TIMEOUT_EN
                     rsp_err   <= 1'b0;
`endif
                     state     <= ST_DONE;
                  end else begin
                     lo_q  <= rx_data;
`ifdef RESP_TIMEOUT_EN
                     tmo_cnt <= '0;
`endif
                     state <= ST_WAIT_HI;
                  end
               end
`ifdef RESP_TIMEOUT_EN
               else if (tmo_hit) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            ST_WAIT_HI: begin
               if (rx_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= join_rsp(rx_data, lo_q);
`ifdef RESP_TIMEOUT_EN
                  rsp_err   <= 1'b0;
`endif
                  state     <= ST_DONE;
               end
`ifdef RESP_TIMEOUT_EN
               else if (tmo_hit) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            ST_DONE: begin
               rsp_valid <= 1'b0;
`ifdef RESP_TIMEOUT_EN
               rsp_err   <= 1'b0;
`endif
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Randomised scoreboard bench for uart_cmd_master: a frame/reply model feeds
// expectation queues that an independent monitor drains.
module tb_uart_cmd_master;

   localparam int TO = 64;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = '0;
   logic [3:0]  req_addr = '0;
   logic [7:0]  req_wdata = '0, req_opa = '0, req_opb = '0;
   logic [3:0]  req_func = '0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_err;

   uart_cmd_master #(
      .FRAME_WIDTH(8), .ALU_DATA_WIDTH(16), .REG_FILE_ADDR_WIDTH(4),
      .ALU_FUNC_WIDTH(4), .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_opa(req_opa),
      .req_opb(req_opb), .req_func(req_func),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] data;
      logic        err;
      int          lat;
   } rsp_t;

   logic [7:0]  exp_tx[$];
   rsp_t        exp_rsp[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          tx_mode = 0;
   int          last_hs_cyc = 0;
   logic [15:0] last_rsp = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // tx_ready: 0 always ready, 1 random back-pressure, 2 held low
   initial forever begin
      @(posedge CLK);
      #1;
      case (tx_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ($urandom_range(0, 3) != 0);
         default: tx_ready = 1'b0;
      endcase
   end

   // Monitor: pops expectations whenever the DUT presents a byte or a response.
   initial begin
      logic       prev_stall;
      logic [7:0] prev_data;
      logic       prev_rv;
      logic [7:0] eb;
      rsp_t       r;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_rv    = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            prev_stall = 1'b0;
            prev_rv    = 1'b0;
         end else begin
            if (tx_valid && prev_stall) chk("tx_hold", tx_data, prev_data);
            if (tx_valid && tx_ready) begin
               if (exp_tx.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_unexpected: got byte %0h expected none", tx_data);
               end else begin
                  eb = exp_tx.pop_front();
                  chk("tx_byte", tx_data, eb);
               end
               last_hs_cyc = cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (rsp_valid) begin
               if (prev_rv) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp_pulse: got rsp_valid high two cycles expected one");
               end
               if (exp_rsp.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp_unexpected: got data %0h expected none", rsp_data);
               end else begin
                  r = exp_rsp.pop_front();
                  chk("rsp_data", rsp_data, r.data);
                  chk("rsp_err", rsp_err, r.err);
                  if (r.lat >= 0) chk("rsp_latency", cyc - last_hs_cyc, r.lat);
                  last_rsp = r.data;
               end
            end
            prev_rv = rsp_valid;
         end
      end
   end

   // Reference model: frame bytes and reply derived from the command rules.
   task automatic do_req(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wd,
                         input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fn,
                         input logic [7:0] lo, input logic [7:0] hi, input bit tmo);
      rsp_t r;
      int   n;
      case (op)
         2'd0: begin exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, addr}); exp_tx.push_back(wd); end
         2'd1: begin exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, addr}); end
         2'd2: begin
            exp_tx.push_back(8'hCC); exp_tx.push_back(opa);
            exp_tx.push_back(opb);   exp_tx.push_back({4'h0, fn});
         end
         default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, fn}); end
      endcase
      r.err = tmo;
      r.lat = -1;
      if (tmo) begin
         r.data = 16'h0000;
         r.lat  = TO + 1;
      end else if (op == 2'd0) begin
         r.data = 16'h0000;
         r.lat  = 1;
      end else if (op == 2'd1) begin
         r.data = {8'h00, lo};
      end else begin
         r.data = {hi, lo};
      end
      exp_rsp.push_back(r);

      n = 0;
      @(negedge CLK);
      while (!req_ready && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (!req_ready) bound_fail("req_ready_wait");
      req_valid = 1'b1;
      req_op = op; req_addr = addr; req_wdata = wd;
      req_opa = opa; req_opb = opb; req_func = fn;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      req_op = 2'($urandom); req_addr = 4'($urandom); req_wdata = 8'($urandom);
      req_opa = 8'($urandom); req_opb = 8'($urandom); req_func = 4'($urandom);

      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while ((exp_tx.size() != 0 || tx_valid) && n < 2000);
      if (exp_tx.size() != 0 || tx_valid) bound_fail("frame_wait");

      if (op != 2'd0 && !tmo) begin
         repeat ($urandom_range(0, 4)) @(negedge CLK);
         rx_valid = 1'b1; rx_data = lo;
         @(negedge CLK);
         rx_valid = 1'b0; rx_data = 8'($urandom);
         if (op[1]) begin
            repeat ($urandom_range(0, 4)) @(negedge CLK);
            rx_valid = 1'b1; rx_data = hi;
            @(negedge CLK);
            rx_valid = 1'b0; rx_data = 8'($urandom);
         end
      end

      n = 0;
      while (exp_rsp.size() != 0 && n < TO + 100) begin
         @(negedge CLK);
         n++;
      end
      if (exp_rsp.size() != 0) begin
         bound_fail("rsp_wait");
         exp_rsp.delete();
         exp_tx.delete();
      end
   endtask

   initial begin
      int n;
      #12;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, 16'h0000);
      chk("rst_rsp_err", rsp_err, 1'b0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      tx_mode = 0;
      do_req(2'd0, 4'h0, 8'h02, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0);
      do_req(2'd1, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h02, 8'h00, 1'b0);

      fork
         do_req(2'd2, 4'h0, 8'h00, 8'h02, 8'h03, 4'h0, 8'h05, 8'h00, 1'b0);
         begin
            repeat (3) @(posedge CLK);
            tx_mode = 2;
            repeat (5) @(posedge CLK);
            tx_mode = 0;
         end
      join

      do_req(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1, 8'h34, 8'h12, 1'b0);
      @(negedge CLK);
      rx_valid = 1'b1; rx_data = 8'h5A;
      @(negedge CLK);
      rx_valid = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rsp_hold_idle", rsp_data, last_rsp);
      chk("req_ready_idle", req_ready, 1'b1);

`ifdef RESP_TIMEOUT_EN
      do_req(2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1);
      do_req(2'd3, 4'h2, 8'h00, 8'h00, 8'h00, 4'h9, 8'hA1, 8'hB2, 1'b0);
`endif

      for (int i = 0; i < 40; i++) begin
         tx_mode = $urandom_range(0, 1);
         do_req(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                4'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      end

      // Reset in the middle of a write frame, with the address byte pending.
      tx_mode = 2;
      @(negedge CLK);
      exp_tx.push_back(8'hAA); exp_tx.push_back(8'h05); exp_tx.push_back(8'h77);
      req_valid = 1'b1; req_op = 2'd0; req_addr = 4'h5; req_wdata = 8'h77;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      tx_mode = 0;
      n = 0;
      do begin
         @(posedge CLK);
         n++;
      end while (exp_tx.size() != 2 && n < 50);
      tx_mode = 2;
      if (exp_tx.size() != 2) bound_fail("mid_frame_wait");
      @(negedge CLK);
      chk("mid_tx_valid", tx_valid, 1'b1);
      chk("mid_tx_data", tx_data, 8'h05);
      #2;
      RST = 1'b0;
      #1;
      chk("rst_mid_tx_valid", tx_valid, 1'b0);
      chk("rst_mid_req_ready", req_ready, 1'b1);
      chk("rst_mid_rsp_data", rsp_data, 16'h0000);
      chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
      exp_tx.delete();
      exp_rsp.delete();
      last_rsp = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      tx_mode = 1;
      do_req(2'd0, 4'h3, 8'hC4, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0);
      do_req(2'd2, 4'hF, 8'h00, 8'hFF, 8'h80, 4'hF, 8'hEE, 8'hFF, 1'b0);

      repeat (5) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by cycle %0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
